cal_date_counter: RTL and testbench

Parametrised calendar date register (day, month, year) for the RTC set/run path. It replaces the per-field set counters with one block that applies real calendar limits: 28/29/30/31-day months and leap years. It supports user edit (up/down on a selected field) and run-mode day advance with day→month→year carry. It sits between the button debouncer/field-select FSM and the display/RTC write path.

---
 rtl/cal_date_counter_pkg.sv | 30 +++
 rtl/cal_date_counter_cnt.sv | 59 +++++
 rtl/cal_date_counter.sv | 134 +++++++++++++
 tb/tb_cal_date_counter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cal_date_counter_pkg.sv
// Shared calendar definitions for the RTC date path: field-select codes,
// month bounds and the month-length rule used by the date counter.
package rtc_pkg;

    localparam logic [1:0] SEL_DAY   = 2'd0;
    localparam logic [1:0] SEL_MONTH = 2'd1;
    localparam logic [1:0] SEL_YEAR  = 2'd2;
    localparam logic [1:0] SEL_NONE  = 2'd3;

    localparam logic [4:0] DAY_MIN   = 5'd1;
    localparam logic [3:0] MONTH_MIN = 4'd1;
    localparam logic [3:0] MONTH_MAX = 4'd12;

    // Leap years are every fourth year counted from a base of 2000.
    function automatic logic is_leap(input logic [1:0] year_lsb);
        return (year_lsb == 2'd0);
    endfunction

    function automatic logic [4:0] days_in_month(input logic [3:0] month,
                                                 input logic       leap);
        logic [4:0] lim;
        case (month)
            4'd4, 4'd6, 4'd9, 4'd11: lim = 5'd30;
            4'd2:                    lim = leap ? 5'd29 : 5'd28;
            default:                 lim = 5'd31;
        endcase
        return lim;
    endfunction

endpackage

// File: rtl/cal_date_counter_cnt.sv
// Up/down counter bounded by a fixed minimum and a run-time maximum, with
// selectable wrap/saturate at the bounds and a priority parallel load.
module bounded_updown_cnt #(
    parameter int W   = 5,
    parameter int MIN = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] max,
    input  logic         inc,
    input  logic         dec,
    input  logic         wrap,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] q,
    output logic [W-1:0] q_nxt,
    output logic         at_max
);

    localparam logic [W-1:0] MIN_V = W'(MIN);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // A value above max counts as "at max" so a stale value can only be
    // wrapped back into range, never stepped further out of it.
    assign at_max = (cnt_q >= max);

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (inc) begin
            if (at_max) begin
                cnt_d = wrap ? MIN_V : cnt_q;
            end else begin
                cnt_d = cnt_q + W'(1);
            end
        end else if (dec) begin
            if (cnt_q == MIN_V) begin
                cnt_d = wrap ? max : cnt_q;
            end else begin
                cnt_d = cnt_q - W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= MIN_V;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q     = cnt_q;
    assign q_nxt = cnt_d;

endmodule

// File: rtl/cal_date_counter.sv
// Calendar date register (day/month/year) with per-field edit and run-mode
// day advance; enforces month lengths and leap years on every edge.
module cal_date_counter
    import rtc_pkg::*;
#(
    parameter int YEAR_W   = 7,
    parameter int YEAR_MAX = 99,
    parameter int WRAP     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        sel,
    input  logic              aumento,
    input  logic              disminuye,
    input  logic              day_tick,
    output logic [4:0]        day,
    output logic [3:0]        month,
    output logic [YEAR_W-1:0] year,
    output logic              year_wrap
);

    localparam logic [YEAR_W-1:0] YEAR_MAX_V = YEAR_W'(YEAR_MAX);
    localparam logic              WRAP_EN    = (WRAP != 0);

    logic              edit_day;
    logic              edit_month;
    logic              edit_year;
    logic              run_tick;
    logic              step_up;
    logic              step_dn;
    logic              field_wrap;

    logic [4:0]        day_q;
    logic [3:0]        month_q;
    logic [YEAR_W-1:0] year_q;
    logic [4:0]        unused_day_nxt;
    logic [3:0]        month_nxt;
    logic [YEAR_W-1:0] year_nxt;
    logic              day_at_max;
    logic              month_at_max;
    logic              year_at_max;

    logic [4:0]        lim_cur;
    logic [4:0]        lim_nxt;
    logic              clamp;

    logic              year_wrap_q;
    logic              year_wrap_d;

    assign edit_day   = (sel == SEL_DAY);
    assign edit_month = (sel == SEL_MONTH);
    assign edit_year  = (sel == SEL_YEAR);
    assign run_tick   = (sel == SEL_NONE) && day_tick;

    // aumento wins when both buttons are held.
    assign step_up    = aumento;
    assign step_dn    = !aumento && disminuye;

    // Run-mode carries always roll over; only user edits may saturate.
    assign field_wrap = (sel == SEL_NONE) ? 1'b1 : WRAP_EN;

    assign lim_cur = days_in_month(month_q, is_leap(year_q[1:0]));
    assign lim_nxt = days_in_month(month_nxt, is_leap(year_nxt[1:0]));

    // Editing month or year can shorten the month under the current day.
    assign clamp = (edit_month || edit_year) && (day_q > lim_nxt);

    bounded_updown_cnt #(
        .W   (5),
        .MIN (1)
    ) u_day (
        .clk      (clk),
        .rst      (rst),
        .max      (lim_cur),
        .inc      ((edit_day && step_up) || run_tick),
        .dec      (edit_day && step_dn),
        .wrap     (field_wrap),
        .load     (clamp),
        .load_val (lim_nxt),
        .q        (day_q),
        .q_nxt    (unused_day_nxt),
        .at_max   (day_at_max)
    );

    bounded_updown_cnt #(
        .W   (4),
        .MIN (1)
    ) u_month (
        .clk      (clk),
        .rst      (rst),
        .max      (MONTH_MAX),
        .inc      ((edit_month && step_up) || (run_tick && day_at_max)),
        .dec      (edit_month && step_dn),
        .wrap     (field_wrap),
        .load     (1'b0),
        .load_val (MONTH_MIN),
        .q        (month_q),
        .q_nxt    (month_nxt),
        .at_max   (month_at_max)
    );

    bounded_updown_cnt #(
        .W   (YEAR_W),
        .MIN (0)
    ) u_year (
        .clk      (clk),
        .rst      (rst),
        .max      (YEAR_MAX_V),
        .inc      ((edit_year && step_up) || (run_tick && day_at_max && month_at_max)),
        .dec      (edit_year && step_dn),
        .wrap     (field_wrap),
        .load     (1'b0),
        .load_val ('0),
        .q        (year_q),
        .q_nxt    (year_nxt),
        .at_max   (year_at_max)
    );

    assign year_wrap_d = run_tick && day_at_max && month_at_max && year_at_max;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            year_wrap_q <= 1'b0;
        end else begin
            year_wrap_q <= year_wrap_d;
        end
    end

    assign day       = day_q;
    assign month     = month_q;
    assign year      = year_q;
    assign year_wrap = year_wrap_q;

endmodule

// File: tb/tb_cal_date_counter.sv
// Directed bench for cal_date_counter: one wrapping and one saturating
// instance share the same stimulus; expected dates are hand-computed.
module tb_cal_date_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] sel;
    logic       aumento;
    logic       disminuye;
    logic       day_tick;

    logic [4:0] day_w, day_s;
    logic [3:0] month_w, month_s;
    logic [6:0] year_w, year_s;
    logic       yw_w, yw_s;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    cal_date_counter #(.YEAR_W(7), .YEAR_MAX(99), .WRAP(1)) u_wrap (
        .clk(clk), .rst(rst), .sel(sel), .aumento(aumento), .disminuye(disminuye),
        .day_tick(day_tick), .day(day_w), .month(month_w), .year(year_w), .year_wrap(yw_w)
    );

    cal_date_counter #(.YEAR_W(7), .YEAR_MAX(99), .WRAP(0)) u_sat (
        .clk(clk), .rst(rst), .sel(sel), .aumento(aumento), .disminuye(disminuye),
        .day_tick(day_tick), .day(day_s), .month(month_s), .year(year_s), .year_wrap(yw_s)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Async reset, then walk the fields up with edits; leaves sel idle.
    task automatic set_date(input int d, input int m, input int y);
        aumento = 1'b0; disminuye = 1'b0; day_tick = 1'b0;
        rst = 1'b1; #1; rst = 1'b0;
        aumento = 1'b1;
        sel = 2'd2; repeat (y) cyc();
        sel = 2'd1; repeat (m - 1) cyc();
        sel = 2'd0; repeat (d - 1) cyc();
        aumento = 1'b0;
        sel = 2'd3;
    endtask

    task automatic test_reset();
        vecs++;
        if ({day_w, month_w, year_w, yw_w} !== {5'd1, 4'd1, 7'd0, 1'b0}) begin
            errs++;
            $display("FAIL reset_init_wrap: got %0d/%0d/%0d w%0d, want 1/1/0 w0", day_w, month_w, year_w, yw_w);
        end
        vecs++;
        if ({day_s, month_s, year_s, yw_s} !== {5'd1, 4'd1, 7'd0, 1'b0}) begin
            errs++;
            $display("FAIL reset_init_sat: got %0d/%0d/%0d w%0d, want 1/1/0 w0", day_s, month_s, year_s, yw_s);
        end
        set_date(15, 6, 7);
        vecs++;
        if ({day_w, month_w, year_w} !== {5'd15, 4'd6, 7'd7}) begin
            errs++;
            $display("FAIL setup_15_6_7: got %0d/%0d/%0d, want 15/6/7", day_w, month_w, year_w);
        end
        sel = 2'd0; aumento = 1'b1;
        #2 rst = 1'b1;
        #1;
        vecs++;
        if ({day_w, month_w, year_w, yw_w} !== {5'd1, 4'd1, 7'd0, 1'b0}) begin
            errs++;
            $display("FAIL reset_mid_edit: got %0d/%0d/%0d w%0d, want 1/1/0 w0", day_w, month_w, year_w, yw_w);
        end
        rst = 1'b0; aumento = 1'b0;
        set_date(31, 12, 99);
        day_tick = 1'b1; cyc(); day_tick = 1'b0;
        #2 rst = 1'b1;
        #1;
        vecs++;
        if ({day_w, month_w, year_w, yw_w} !== {5'd1, 4'd1, 7'd0, 1'b0}) begin
            errs++;
            $display("FAIL reset_mid_carry: got %0d/%0d/%0d w%0d, want 1/1/0 w0", day_w, month_w, year_w, yw_w);
        end
        rst = 1'b0;
    endtask

    task automatic test_leap_carry();
        set_date(28, 2, 4);
        day_tick = 1'b1; cyc(); day_tick = 1'b0;
        vecs++;
        if ({day_w, month_w, year_w} !== {5'd29, 4'd2, 7'd4}) begin
            errs++;
            $display("FAIL leap4_to_29feb: got %0d/%0d/%0d, want 29/2/4", day_w, month_w, year_w);
        end
        day_tick = 1'b1; cyc(); day_tick = 1'b0;
        vecs++;
        if ({day_w, month_w, year_w} !== {5'd1, 4'd3, 7'd4}) begin
            errs++;
            $display("FAIL leap4_to_1mar: got %0d/%0d/%0d, want 1/3/4", day_w, month_w, year_w);
        end
        vecs++;
        if ({day_s, month_s, year_s} !== {5'd1, 4'd3, 7'd4}) begin
            errs++;
            $display("FAIL leap4_to_1mar_sat: got %0d/%0d/%0d, want 1/3/4", day_s, month_s, year_s);
        end
        set_date(28, 2, 5);
        day_tick = 1'b1; cyc(); day_tick = 1'b0;
        vecs++;
        if ({day_w, month_w, year_w} !== {5'd1, 4'd3, 7'd5}) begin
            errs++;
            $display("FAIL year5_to_1mar: got %0d/%0d/%0d, want 1/3/5", day_w, month_w, year_w);
        end
        set_date(30, 4, 5);
        day_tick = 1'b1; cyc(); day_tick = 1'b0;
        vecs++;
        if ({day_w, month_w, year_w} !== {5'd1, 4'd5, 7'd5}) begin
            errs++;
            $display("FAIL 30apr_to_1may: got %0d/%0d/%0d, want 1/5/5", day_w, month_w, year_w);
        end
    endtask

    task automatic test_year_rollover();
        set_date(31, 12, 98);
        day_tick = 1'b1; cyc(); day_tick = 1'b0;
        vecs++;
        if ({day_w, month_w, year_w, yw_w} !== {5'd1, 4'd1, 7'd99, 1'b0}) begin
            errs++;
            $display("FAIL newyear_98: got %0d/%0d/%0d w%0d, want 1/1/99 w0", day_w, month_w, year_w, yw_w);
        end
        set_date(31, 12, 99);
        day_tick = 1'b1; cyc(); day_tick = 1'b0;
        vecs++;
        if ({day_w, month_w, year_w, yw_w} !== {5'd1, 4'd1, 7'd0, 1'b1}) begin
            errs++;
            $display("FAIL rollover_wrap: got %0d/%0d/%0d w%0d, want 1/1/0 w1", day_w, month_w, year_w, yw_w);
        end
        vecs++;
        if ({day_s, month_s, year_s, yw_s} !== {5'd1, 4'd1, 7'd0, 1'b1}) begin
            errs++;
            $display("FAIL rollover_sat: got %0d/%0d/%0d w%0d, want 1/1/0 w1", day_s, month_s, year_s, yw_s);
        end
        cyc();
        vecs++;
        if ({day_w, month_w, year_w, yw_w} !== {5'd1, 4'd1, 7'd0, 1'b0}) begin
            errs++;
            $display("FAIL rollover_pulse_end: got %0d/%0d/%0d w%0d, want 1/1/0 w0", day_w, month_w, year_w, yw_w);
        end
    endtask

    task automatic test_clamp();
        set_date(31, 1, 1);
        sel = 2'd1; aumento = 1'b1; cyc(); aumento = 1'b0; sel = 2'd3;
        vecs++;
        if ({day_w, month_w, year_w} !== {5'd28, 4'd2, 7'd1}) begin
            errs++;
            $display("FAIL clamp_jan_inc: got %0d/%0d/%0d, want 28/2/1", day_w, month_w, year_w);
        end
        set_date(31, 3, 0);
        sel = 2'd1; disminuye = 1'b1; cyc(); disminuye = 1'b0; sel = 2'd3;
        vecs++;
        if ({day_w, month_w, year_w} !== {5'd29, 4'd2, 7'd0}) begin
            errs++;
            $display("FAIL clamp_mar_dec_leap: got %0d/%0d/%0d, want 29/2/0", day_w, month_w, year_w);
        end
        sel = 2'd2; aumento = 1'b1; cyc(); aumento = 1'b0; sel = 2'd3;
        vecs++;
        if ({day_w, month_w, year_w} !== {5'd28, 4'd2, 7'd1}) begin
            errs++;
            $display("FAIL clamp_year_inc: got %0d/%0d/%0d, want 28/2/1", day_w, month_w, year_w);
        end
    endtask

    task automatic test_edit_bounds();
        set_date(31, 1, 0);
        sel = 2'd0; aumento = 1'b1; cyc(); aumento = 1'b0;
        vecs++;
        if ({day_w, day_s} !== {5'd1, 5'd31}) begin
            errs++;
            $display("FAIL day_inc_at_31: got wrap=%0d sat=%0d, want wrap=1 sat=31", day_w, day_s);
        end
        set_date(1, 1, 0);
        sel = 2'd0; disminuye = 1'b1; cyc(); disminuye = 1'b0;
        vecs++;
        if ({day_w, day_s} !== {5'd31, 5'd1}) begin
            errs++;
            $display("FAIL day_dec_at_1: got wrap=%0d sat=%0d, want wrap=31 sat=1", day_w, day_s);
        end
        set_date(1, 1, 0);
        sel = 2'd1; disminuye = 1'b1; cyc(); disminuye = 1'b0;
        vecs++;
        if ({month_w, month_s} !== {4'd12, 4'd1}) begin
            errs++;
            $display("FAIL month_dec_at_1: got wrap=%0d sat=%0d, want wrap=12 sat=1", month_w, month_s);
        end
        set_date(1, 12, 0);
        sel = 2'd1; aumento = 1'b1; cyc(); aumento = 1'b0;
        vecs++;
        if ({month_w, month_s} !== {4'd1, 4'd12}) begin
            errs++;
            $display("FAIL month_inc_at_12: got wrap=%0d sat=%0d, want wrap=1 sat=12", month_w, month_s);
        end
        set_date(1, 1, 0);
        sel = 2'd2; disminuye = 1'b1; cyc(); disminuye = 1'b0;
        vecs++;
        if ({year_w, year_s} !== {7'd99, 7'd0}) begin
            errs++;
            $display("FAIL year_dec_at_0: got wrap=%0d sat=%0d, want wrap=99 sat=0", year_w, year_s);
        end
        set_date(1, 1, 99);
        sel = 2'd2; aumento = 1'b1; cyc(); aumento = 1'b0;
        vecs++;
        if ({year_w, year_s, yw_w} !== {7'd0, 7'd99, 1'b0}) begin
            errs++;
            $display("FAIL year_inc_at_99: got wrap=%0d sat=%0d w%0d, want wrap=0 sat=99 w0", year_w, year_s, yw_w);
        end
        sel = 2'd3;
    endtask

    task automatic test_priority();
        set_date(1, 1, 50);
        sel = 2'd2; aumento = 1'b1; disminuye = 1'b1; cyc();
        aumento = 1'b0; disminuye = 1'b0;
        vecs++;
        if ({day_w, month_w, year_w} !== {5'd1, 4'd1, 7'd51}) begin
            errs++;
            $display("FAIL both_buttons: got %0d/%0d/%0d, want 1/1/51", day_w, month_w, year_w);
        end
        disminuye = 1'b1; cyc(); disminuye = 1'b0;
        vecs++;
        if (year_w !== 7'd50) begin
            errs++;
            $display("FAIL year_dec: got %0d, want 50", year_w);
        end
        day_tick = 1'b1; cyc(); day_tick = 1'b0;
        vecs++;
        if ({day_w, month_w, year_w} !== {5'd1, 4'd1, 7'd50}) begin
            errs++;
            $display("FAIL tick_in_edit: got %0d/%0d/%0d, want 1/1/50", day_w, month_w, year_w);
        end
        sel = 2'd3; aumento = 1'b1; cyc(); aumento = 1'b0;
        vecs++;
        if ({day_w, month_w, year_w} !== {5'd1, 4'd1, 7'd50}) begin
            errs++;
            $display("FAIL inc_in_run: got %0d/%0d/%0d, want 1/1/50", day_w, month_w, year_w);
        end
        sel = 2'd0; aumento = 1'b1; cyc(); aumento = 1'b0; sel = 2'd3;
        vecs++;
        if ({day_w, month_w, year_w} !== {5'd2, 4'd1, 7'd50}) begin
            errs++;
            $display("FAIL sel_and_step_same_cycle: got %0d/%0d/%0d, want 2/1/50", day_w, month_w, year_w);
        end
    endtask

    initial begin
        rst = 1'b1; sel = 2'd3; aumento = 1'b0; disminuye = 1'b0; day_tick = 1'b0;
        #2;
        test_reset();
        test_leap_carry();
        test_year_rollover();
        test_clamp();
        test_edit_bounds();
        test_priority();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
